message_frame_serializer: RTL and testbench

//  Parametrised message-to-symbol serializer controller with its own datapath.
//  - Accepts a MSG_W-bit message on a send/ready handshake.
//  - Emits it MSB-first as SYM_BITS-wide symbols; each symbol is held SAMPLES_PER_SYM cycles.
//  - Feeds the modulator stage. Supports back-to-back messages with no idle gap.

---
 rtl/message_frame_serializer_pkg.sv | 27 ++
 rtl/message_frame_serializer_if.sv | 25 ++
 rtl/mod_n_counter.sv | 39 +++
 rtl/message_frame_serializer.sv | 122 ++++++++++++
 tb/tb_message_frame_serializer.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/message_frame_serializer_pkg.sv
// Shared types and sizing helpers for the message frame serializer.
// Optional preamble support is selected with the PREAMBLE_EN macro.
package message_pkg;

   // Frame state encoding.
   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StData = 2'b01,
      StPre  = 2'b10
   } state_e;

   // Number of symbols carried by one message.
   function automatic int unsigned calc_nsym(input int unsigned msg_w,
                                             input int unsigned sym_bits);
      return msg_w / sym_bits;
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Counter width for a modulo-n count; never below one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/message_frame_serializer_if.sv
// Message-in / symbol-out bus of the frame serializer.
// master: the message source and symbol consumer; slave: the serializer.
interface message_frame_serializer_if #(
   parameter int unsigned MSG_W    = 16,
   parameter int unsigned SYM_BITS = 2
);
   logic                send;
   logic [MSG_W-1:0]    msg_in;
   logic                ready;
   logic                busy;
   logic [SYM_BITS-1:0] sym_out;
   logic                sym_valid;
   logic                sym_start;
   logic                done;

   modport master (
      output send, msg_in,
      input  ready, busy, sym_out, sym_valid, sym_start, done
   );

   modport slave (
      input  send, msg_in,
      output ready, busy, sym_out, sym_valid, sym_start, done
   );
endinterface

// File: rtl/mod_n_counter.sv
// Modulo-N counter with synchronous init, count enable and wrap flag (co).
// init has priority over en; co is high on an enabled cycle at count N-1.
module mod_n_counter
   import message_pkg::*;
#(
   parameter int unsigned N = 10,
   parameter int unsigned W = cnt_width(N)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         init,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         co
);
   logic [W-1:0] count_q, count_d;

   assign co    = en && (count_q == W'(N - 1));
   assign count = count_q;

   // Next count: clear on init, otherwise advance and wrap when enabled.
   always_comb begin
      count_d = count_q;
      if (init) begin
         count_d = '0;
      end else if (en) begin
         count_d = co ? '0 : count_q + W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end
endmodule

// File: rtl/message_frame_serializer.sv
// Message-to-symbol serializer: accepts a message on send/ready and emits it
// MSB-first as SYM_BITS-wide symbols, each held SAMPLES_PER_SYM cycles.
// Define PREAMBLE_EN to prefix each frame with PRE_LEN alternating symbols.
module message_frame_serializer
   import message_pkg::*;
#(
   parameter int unsigned MSG_W           = 16,
   parameter int unsigned SYM_BITS        = 2,
   parameter int unsigned SAMPLES_PER_SYM = 10,
   parameter int unsigned PRE_LEN         = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   message_frame_serializer_if.slave    bus
);
   localparam int unsigned NSYM    = calc_nsym(MSG_W, SYM_BITS);
   localparam int unsigned SYM_MOD = max_u(NSYM, PRE_LEN);
   localparam int unsigned SW      = cnt_width(SAMPLES_PER_SYM);
   localparam int unsigned YW      = cnt_width(SYM_MOD);

`ifdef PREAMBLE_EN
   localparam state_e StStart = StPre;
`else
   localparam state_e StStart = StData;
`endif

   state_e           state_q, state_d;
   logic [MSG_W-1:0] shreg_q, shreg_d;
   logic [SW-1:0]    sample_cnt;
   logic [YW-1:0]    sym_cnt;
   logic             sample_co, sym_co;
   logic             active, is_data, is_pre;
   logic             accept, last_data, pre_last, sym_init;
   logic             unused_sym_co;

   assign active    = (state_q != StIdle);
   assign is_data   = (state_q == StData);
   assign is_pre    = (state_q == StPre);
   assign last_data = is_data && sample_co && (sym_cnt == YW'(NSYM - 1));
   assign pre_last  = is_pre && sample_co && (sym_cnt == YW'(PRE_LEN - 1));
   assign accept    = bus.send && bus.ready;
   // Symbol count restarts at every phase boundary, so it is 0 whenever idle.
   assign sym_init  = accept || pre_last || last_data;
   // Phase ends are decoded from sym_cnt directly; the full-range wrap is redundant.
   assign unused_sym_co = sym_co;

   mod_n_counter #(
      .N (SAMPLES_PER_SYM),
      .W (SW)
   ) u_sample_cnt (
      .clk   (clk),
      .reset (reset),
      .init  (accept),
      .en    (active),
      .count (sample_cnt),
      .co    (sample_co)
   );

   mod_n_counter #(
      .N (SYM_MOD),
      .W (YW)
   ) u_sym_cnt (
      .clk   (clk),
      .reset (reset),
      .init  (sym_init),
      .en    (sample_co),
      .count (sym_cnt),
      .co    (sym_co)
   );

   // Frame state sequencing; a send on the final sample restarts with no gap.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (accept) state_d = StStart;
`ifdef PREAMBLE_EN
         StPre:  if (pre_last) state_d = StData;
`endif
         StData: if (last_data) state_d = accept ? StStart : StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Shift register: load on accept, shift one symbol at each DATA symbol end.
   always_comb begin
      shreg_d = shreg_q;
      if (accept) begin
         shreg_d = bus.msg_in;
      end else if (is_data && sample_co) begin
         shreg_d = {shreg_q[MSG_W-SYM_BITS-1:0], {SYM_BITS{1'b0}}};
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
      end
   end

   // Output decode; preamble symbols alternate all-ones / all-zeros.
   always_comb begin
      bus.sym_out = '0;
      if (is_data) begin
         bus.sym_out = shreg_q[MSG_W-1 -: SYM_BITS];
      end
`ifdef PREAMBLE_EN
      else if (is_pre) begin
         bus.sym_out = sym_cnt[0] ? '0 : '1;
      end
`endif
      bus.ready     = !active || last_data;
      bus.busy      = active;
      bus.sym_valid = active;
      bus.sym_start = active && (sample_cnt == '0);
      bus.done      = last_data;
   end
endmodule

// File: tb/tb_message_frame_serializer.sv
// Self-checking bench for message_frame_serializer (default parameters).
module tb_message_frame_serializer;
   localparam int MSG_W    = 16;
   localparam int SYM_BITS = 2;
   localparam int SPS      = 10;
   localparam int PRE_LEN  = 4;
   localparam int NSYM     = MSG_W / SYM_BITS;
`ifdef PREAMBLE_EN
   localparam int PL = PRE_LEN;
`else
   localparam int PL = 0;
`endif
   localparam int TOTAL = (PL + NSYM) * SPS;
   localparam int MASK  = (1 << SYM_BITS) - 1;

   logic clk = 1'b0;
   logic reset;

   message_frame_serializer_if #(.MSG_W(MSG_W), .SYM_BITS(SYM_BITS)) bus ();

   message_frame_serializer #(
      .MSG_W           (MSG_W),
      .SYM_BITS        (SYM_BITS),
      .SAMPLES_PER_SYM (SPS),
      .PRE_LEN         (PRE_LEN)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: frame position k within a frame of TOTAL cycles.
   bit          m_in  = 1'b0;
   int          m_k   = 0;
   logic [31:0] m_msg = '0;

   always @(negedge clk) begin
      int s, smp, e_sym;
      bit e_valid, e_start, e_done, e_ready, e_busy;
      if (reset) m_in = 1'b0;
      if (m_in) begin
         s       = m_k / SPS;
         smp     = m_k % SPS;
         e_valid = 1'b1;
         e_start = (smp == 0);
         e_done  = (m_k == TOTAL - 1);
         e_ready = e_done;
         e_busy  = 1'b1;
         if (s < PL) e_sym = (s % 2 == 0) ? MASK : 0;
         else e_sym = int'((m_msg >> (MSG_W - SYM_BITS * (s - PL + 1))) & MASK);
      end else begin
         e_sym = 0; e_valid = 0; e_start = 0; e_done = 0; e_ready = 1; e_busy = 0;
      end
      check("model sym_out",   32'(bus.sym_out),   32'(e_sym));
      check("model sym_valid", 32'(bus.sym_valid), 32'(e_valid));
      check("model sym_start", 32'(bus.sym_start), 32'(e_start));
      check("model done",      32'(bus.done),      32'(e_done));
      check("model ready",     32'(bus.ready),     32'(e_ready));
      check("model busy",      32'(bus.busy),      32'(e_busy));
      if (!reset) begin
         if (bus.send && e_ready) begin
            m_in  = 1'b1;
            m_k   = 0;
            m_msg = 32'(bus.msg_in);
         end else if (m_in) begin
            m_k++;
            if (m_k == TOTAL) m_in = 1'b0;
         end
      end
   end

`ifndef PREAMBLE_EN
   // One B41E frame with literal expectations; optional busy send or reset.
   task automatic directed(input int busy_k, input int reset_k);
      int lit [8] = '{2, 3, 1, 0, 0, 1, 3, 2};
      bit aborted = 1'b0;
      bus.send   = 1'b1;
      bus.msg_in = 16'hB41E;
      step();
      bus.send = 1'b0;
      for (int k = 0; k < 80 && !aborted; k++) begin
         @(negedge clk);
         check("lit sym_out", 32'(bus.sym_out), 32'(lit[k / 10]));
         check("lit done", 32'(bus.done), 32'(k == 79));
         step();
         if (k + 1 == busy_k) begin
            bus.send   = 1'b1;
            bus.msg_in = 16'h1234;
         end
         if (k == busy_k) bus.send = 1'b0;
         if (k + 1 == reset_k) begin
            reset = 1'b1;
            @(negedge clk);
            check("rst sym_valid", 32'(bus.sym_valid), 32'd0);
            check("rst sym_out",   32'(bus.sym_out),   32'd0);
            check("rst done",      32'(bus.done),      32'd0);
            check("rst ready",     32'(bus.ready),     32'd1);
            step();
            reset   = 1'b0;
            aborted = 1'b1;
         end
      end
      if (!aborted) begin
         @(negedge clk);
         check("end ready", 32'(bus.ready), 32'd1);
         check("end busy",  32'(bus.busy),  32'd0);
         step();
      end
   endtask

   // FFFF then 0000 back to back: 160 contiguous valid cycles.
   task automatic back_to_back();
      bus.send   = 1'b1;
      bus.msg_in = 16'hFFFF;
      step();
      bus.msg_in = 16'h0000;
      for (int k = 0; k < 160; k++) begin
         @(negedge clk);
         check("b2b valid", 32'(bus.sym_valid), 32'd1);
         check("b2b sym", 32'(bus.sym_out), (k < 80) ? 32'd3 : 32'd0);
         check("b2b done", 32'(bus.done), 32'(k == 79 || k == 159));
         step();
         if (k == 79) bus.send = 1'b0;
      end
      @(negedge clk);
      check("b2b idle valid", 32'(bus.sym_valid), 32'd0);
      step();
   endtask
`endif

   initial begin
      reset      = 1'b1;
      bus.send   = 1'b0;
      bus.msg_in = '0;
      #1;
      @(negedge clk);
      check("reset ready", 32'(bus.ready), 32'd1);
      check("reset busy",  32'(bus.busy),  32'd0);
      check("reset valid", 32'(bus.sym_valid), 32'd0);
      repeat (3) step();
      reset = 1'b0;
      step();
`ifndef PREAMBLE_EN
      directed(-1, -1);
      directed(20, -1);
      directed(-1, 35);
      directed(-1, -1);
      back_to_back();
`endif
      for (int i = 0; i < 3000; i++) begin
         bus.send   = ($urandom_range(3) == 0);
         bus.msg_in = MSG_W'($urandom);
         reset      = ($urandom_range(499) == 0);
         step();
      end
      reset    = 1'b0;
      bus.send = 1'b0;
      repeat (TOTAL + 2) step();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
